formant_frame_scheduler: RTL
============================

Name: formant_frame_scheduler

Overview:
- Front-end controller that sequences FFT frames into the formant engine. The engine accepts one I-bin frame and then runs for a long, variable time.
- Admits a frame only when the engine is idle and drops whole frames arriving while it is busy.
- Runs a watchdog on the engine and resets it on timeout.
- Latches each formant result and presents it as a single-cycle pulse, together with drop and timeout statistics.

Parameters:
- BIT_WIDTH, 32, width of FFT samples and of each formant frequency word
- I, 160, bins per FFT frame
- FORMANTS, 5, formant words per result
- TIMEOUT, 1000000, max cycles in WAIT before the engine is declared hung
- RECOVER_CYCLES, 4, cycles eng_rst is held after a timeout
- CNT_WIDTH, 16, width of the statistics counters

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- fft_valid  in  1  upstream FFT bin valid; gaps allowed mid-frame
- fft_data  in  BIT_WIDTH  upstream FFT bin
- eng_fft_valid  out  1  bin valid to engine
- eng_fft_data  out  BIT_WIDTH  bin to engine
- eng_rst  out  1  engine reset: OR of rst_in and the recovery pulse
- eng_formant_valid  in  1  engine result valid; may be held high as a level
- eng_formant_freq  in  FORMANTS*BIT_WIDTH  engine result; word k at [k*BIT_WIDTH +: BIT_WIDTH]
- formant_valid  out  1  one-cycle result pulse
- formant_freq  out  FORMANTS*BIT_WIDTH  latched result, held until the next result
- busy  out  1  high in any state other than IDLE
- frames_dropped  out  CNT_WIDTH  saturating count of dropped frames
- timeouts  out  CNT_WIDTH  saturating count of watchdog firings

Behaviour:
- Reset values: all outputs 0, except eng_rst, which is 1 while rst_in is high. State=IDLE, in_cnt=0, watchdog=0, edge-detect register=0.
- in_cnt counts fft_valid beats 0..I-1 and wraps; it runs in every state. A beat with in_cnt==0 is the first beat of a frame.
- Frame admission:
  - A frame is admitted iff its first beat arrives while state==IDLE. Otherwise the whole frame is dropped and frames_dropped increments once, on that first beat.
  - A frame whose first beat arrives during RECOVER is dropped.
- Forwarding: eng_fft_valid/eng_fft_data are registered copies of fft_valid/fft_data, with 1-cycle latency, for the I beats of an admitted frame only. eng_fft_valid=0 otherwise.
- Result detection: eng_formant_valid is rising-edge detected (current & ~previous). Only a rising edge seen in WAIT is accepted; edges in any other state are ignored.
- State machine IDLE, STREAM, WAIT, RECOVER:
  - IDLE: on an admitted first beat -> STREAM; in_cnt becomes 1.
  - STREAM: on the beat with in_cnt==I-1 -> WAIT; watchdog cleared to 0.
  - WAIT: watchdog increments every cycle.
    - On an accepted edge: latch eng_formant_freq into formant_freq, pulse formant_valid for exactly one cycle (the cycle after the edge), -> IDLE.
    - Else when watchdog==TIMEOUT-1: timeouts++ (saturating), -> RECOVER.
    - If the edge and the timeout occur in the same cycle, the result wins: no timeout is counted.
  - RECOVER: eng_rst=1 for exactly RECOVER_CYCLES cycles, then -> IDLE. formant_freq is unchanged.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- rst_in mid-operation: immediate return to the reset values, and any partial frame is abandoned. The first fft_valid beat after reset is treated as in_cnt==0.
- busy equals (state!=IDLE). It is registered and changes in the same cycle as the state.
- A new admitted frame can begin on the first cycle back in IDLE, including a first beat coincident with the formant_valid pulse.

Test Plan (I=8, FORMANTS=2, BIT_WIDTH=16, TIMEOUT=50, RECOVER_CYCLES=4):
- Eight contiguous beats with data 1..8; engine result edge 20 cycles later with words {300,2200} -> eng_fft_valid shows 1..8 delayed one cycle; formant_freq={300,2200}; formant_valid high 1 cycle; busy back to 0.
- Second frame streamed while in WAIT -> not forwarded; frames_dropped=1. Third frame after the result -> forwarded; frames_dropped stays 1.
- Engine never responds -> RECOVER entered 50 cycles after WAIT entry; eng_rst high 4 cycles; timeouts=1; formant_freq keeps its old value; next frame is admitted.
- eng_formant_valid held high from a previous result across the next WAIT -> no accept; a fresh 0->1 edge is accepted; exactly one formant_valid pulse per frame.
- Result edge in the cycle watchdog==49 -> result accepted, timeouts unchanged, no eng_rst pulse.
- rst_in asserted after 3 beats of a frame -> all outputs 0, eng_rst=1 during reset; the next 8-beat frame is admitted from its first beat and forwarded completely.

Source files
------------

// File: rtl/formant_frame_scheduler.sv
// Front-end scheduler for the formant engine. It admits whole FFT frames only while the engine is idle.
// It guards the engine with a watchdog and turns each engine result into a one-cycle pulse.
module formant_frame_scheduler #(
    parameter int BIT_WIDTH      = 32,
    parameter int I              = 160,
    parameter int FORMANTS       = 5,
    parameter int TIMEOUT        = 1000000,
    parameter int RECOVER_CYCLES = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          fft_valid,
    input  logic [BIT_WIDTH-1:0]          fft_data,
    output logic                          eng_fft_valid,
    output logic [BIT_WIDTH-1:0]          eng_fft_data,
    output logic                          eng_rst,
    input  logic                          eng_formant_valid,
    input  logic [FORMANTS*BIT_WIDTH-1:0] eng_formant_freq,
    output logic                          formant_valid,
    output logic [FORMANTS*BIT_WIDTH-1:0] formant_freq,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          frames_dropped,
    output logic [CNT_WIDTH-1:0]          timeouts
);

    localparam int IW = (I > 1) ? $clog2(I) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    localparam logic [IW-1:0] LAST_BIN = IW'(I - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [RW-1:0] REC_LAST = RW'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT,
        ST_RECOVER
    } state_t;

    state_t        state;
    logic [IW-1:0] in_cnt;
    logic [WW-1:0] watchdog;
    logic [RW-1:0] rec_cnt;
    logic          fv_prev;
    logic          recovering;

    logic first_beat;
    logic last_beat;
    logic admit;
    logic forward;
    logic result_edge;

    assign first_beat  = fft_valid && (in_cnt == '0);
    assign last_beat   = fft_valid && (in_cnt == LAST_BIN);
    assign admit       = first_beat && (state == ST_IDLE);
    assign forward     = admit || (fft_valid && (state == ST_STREAM));
    assign result_edge = eng_formant_valid && !fv_prev;

    // NOTE: eng_rst is combinational on rst_in, so the engine is held in reset in the same cycle rst_in rises.
    assign eng_rst = rst_in || recovering;

    // NOTE: all state updates use non-blocking assignments, so every branch sees the pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            in_cnt         <= '0;
            watchdog       <= '0;
            rec_cnt        <= '0;
            fv_prev        <= 1'b0;
            recovering     <= 1'b0;
            busy           <= 1'b0;
            eng_fft_valid  <= 1'b0;
            eng_fft_data   <= '0;
            formant_valid  <= 1'b0;
            formant_freq   <= '0;
            frames_dropped <= '0;
            timeouts       <= '0;
        end else begin
            fv_prev       <= eng_formant_valid;
            formant_valid <= 1'b0;
            eng_fft_valid <= forward;
            if (forward) begin
                eng_fft_data <= fft_data;
            end

            if (fft_valid) begin
                in_cnt <= (in_cnt == LAST_BIN) ? '0 : in_cnt + IW'(1);
            end

            if (first_beat && (state != ST_IDLE) && (frames_dropped != '1)) begin
                frames_dropped <= frames_dropped + CNT_WIDTH'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (admit) begin
                        busy <= 1'b1;
                        // A single-bin frame is complete on its first beat.
                        if (last_beat) begin
                            state    <= ST_WAIT;
                            watchdog <= '0;
                        end else begin
                            state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (last_beat) begin
                        state    <= ST_WAIT;
                        watchdog <= '0;
                    end
                end
                ST_WAIT: begin
                    watchdog <= watchdog + WW'(1);
                    if (result_edge) begin
                        formant_freq  <= eng_formant_freq;
                        formant_valid <= 1'b1;
                        state         <= ST_IDLE;
                        busy          <= 1'b0;
                    end else if (watchdog == WD_LAST) begin
                        if (timeouts != '1) begin
                            timeouts <= timeouts + CNT_WIDTH'(1);
                        end
                        state      <= ST_RECOVER;
                        rec_cnt    <= '0;
                        recovering <= 1'b1;
                    end
                end
                ST_RECOVER: begin
                    rec_cnt <= rec_cnt + RW'(1);
                    if (rec_cnt == REC_LAST) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        recovering <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    recovering <= 1'b0;
                end
            endcase
        end
    end

endmodule
